turn_scheduler: RTL
===================

# turn_scheduler

Turn sequencer and arbiter for the tic-tac-toe board datapath. Shares the 9-cell position register bank between two move requesters, player and computer, through valid/ready handshakes. Enforces strict alternation, screens moves for legality, and issues one-hot write enables to the board. It reads back win/full status to end the game, and also handles board clear at game start and per-turn timeout forfeits.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles a mover may stall in a wait state before forfeiting; 0 disables timeout
- CNT_W, 8, timeout counter width; TIMEOUT_CYCLES < 2^CNT_W

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a new game; honoured only in IDLE or DONE
- first_comp  in  1  sampled with accepted start; 1 = computer moves first
- pl_valid / pl_pos  in  1 / 4  player move offer; cell index 0..8
- pl_ready  out  1  scheduler accepting a player move
- pc_valid / pc_pos  in  1 / 4  computer move offer; cell index 0..8
- pc_ready  out  1  scheduler accepting a computer move
- cell_occ  in  9  board occupancy; bit i set = cell i non-empty
- win  in  1  board has any three-in-line
- full  in  1  all nine cells occupied
- board_clr  out  1  one-cycle board clear pulse
- wr_en  out  9  one-hot cell write enable
- wr_mark  out  2  mark written: 01 player, 10 computer
- turn  out  2  side to move: 00 none, 01 player, 10 computer
- reject  out  1  offered move illegal this cycle
- timeout  out  1  one-cycle forfeit pulse
- game_over  out  1  level, high in DONE
- result  out  2  00 none, 01 player win, 10 computer win, 11 draw
- move_cnt  out  4  accepted moves this game, 0..9

## Operation
- States: IDLE, CLEAR, WAIT_PL, WAIT_PC, WRITE, CHECK, DONE.
- IDLE or DONE, with start=1: latch first_comp, go to CLEAR.
  - move_cnt, result and game_over clear on entry to CLEAR.
- CLEAR: board_clr=1 for exactly one cycle, then WAIT_PC if first_comp, else WAIT_PL.
- WAIT_PL: pl_ready=1, pc_ready=0, turn=01. WAIT_PC is symmetric: pc_ready=1, turn=10.
  - Offer is legal when pos ≤ 8 and cell_occ[pos]=0. A legal offer is accepted: latch pos and mark, go to WRITE.
  - Offer with pos > 8 or an occupied cell: reject=1 in the same cycle (combinational); state unchanged.
  - Valid from the side not on move: ignored, no reject.
- WRITE: wr_en = one-hot of latched pos, wr_mark = latched mark, for one cycle. move_cnt increments.
- CHECK: board status now reflects the write.
  - win=1: go to DONE, result = mover's mark.
  - else full=1: go to DONE, result=11.
  - else go to the other side's WAIT state.
- DONE: game_over=1; result held until the next CLEAR. Ready signals low.
- Timeout: counter clears on entry to each WAIT state and increments per cycle in WAIT; rejects do not clear it.
  - If TIMEOUT_CYCLES cycles elapse with no accept: timeout=1 for one cycle, go to DONE, result = opponent's mark.
  - An accept in the expiry cycle takes priority over timeout.
- start outside IDLE/DONE: ignored.

## Timing
- Reset values: state IDLE; every output 0; latched pos/mark 0.
  - Reset does not pulse board_clr; the board has its own reset.
- Reset mid-game, in any state: IDLE on the next edge; any pending wr_en dropped.
- Moore outputs, decoded from registered state: pl_ready, pc_ready, turn, wr_en, wr_mark, board_clr, game_over.
- Only combinational output: reject.
- start at edge t: board_clr high in cycle t+1; first WAIT in t+2.
- Accept at cycle t:
  - wr_en in t+1
  - CHECK in t+2
  - next WAIT, or DONE with result valid, in t+3
- Minimum 3 cycles per turn. At most one wr_en bit high at any time, and never in the same cycle as board_clr.
- Ninth move with a win reports a win, not a draw; win has priority over full.

## Test plan
- Reset, start with first_comp=0; player offers pos 4 at once.
  - Response: board_clr one cycle; accept; wr_en=9'h010, wr_mark=01 one cycle later; turn=10 three cycles after accept; move_cnt=1.
- In WAIT_PL, offer pos 4 (occupied), then pos 12.
  - Response: reject=1 each cycle, no wr_en, state stays WAIT_PL.
  - Then pos 0 is accepted.
- Alternate moves P0, C3, P1, C4, P2 (board model drives win).
  - Response: CHECK after P2 sets game_over=1, result=01, move_cnt=5; both ready low.
- Fill the board with no line, e.g. P0 C1 P2 C4 P3 C5 P7 C6 P8.
  - Response: result=11 after the ninth move; move_cnt=9.
- TIMEOUT_CYCLES=4; in WAIT_PC, pc_valid stays low for 4 cycles.
  - Response: timeout pulse; DONE with result=01.
  - Repeat with an accept in the fourth cycle: no timeout.
- Assert reset during WRITE.
  - Response: wr_en low the next cycle; all outputs 0; IDLE.
  - A new start re-issues board_clr.

Source files
------------

// File: rtl/turn_scheduler.sv
// turn_scheduler
// Turn sequencer and arbiter for the tic-tac-toe board datapath. Alternates
// the player and the computer through valid/ready handshakes, screens offered
// moves against the current board occupancy, issues one-hot cell writes,
// reads back win/full to end the game, clears the board at game start and
// forfeits a side that stalls too long on its turn.
module turn_scheduler #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       first_comp,
    input  logic       pl_valid,
    input  logic [3:0] pl_pos,
    output logic       pl_ready,
    input  logic       pc_valid,
    input  logic [3:0] pc_pos,
    output logic       pc_ready,
    input  logic [8:0] cell_occ,
    input  logic       win,
    input  logic       full,
    output logic       board_clr,
    output logic [8:0] wr_en,
    output logic [1:0] wr_mark,
    output logic [1:0] turn,
    output logic       reject,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] result,
    output logic [3:0] move_cnt
);

    localparam logic [1:0] MARK_NONE = 2'b00;
    localparam logic [1:0] MARK_PL   = 2'b01;
    localparam logic [1:0] MARK_PC   = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;

    // A zero timeout disables forfeits; otherwise the last allowed wait cycle
    // is the one in which the counter reads TIMEOUT_CYCLES-1.
    localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        TIMEOUT_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_PL,
        S_WAIT_PC,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       pos_q;
    logic [1:0]       mark_q;
    logic             first_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       move_cnt_q;
    logic [1:0]       result_q;
    logic             timeout_q;

    logic             in_wait;
    logic             offer_valid;
    logic [3:0]       offer_pos;
    logic [1:0]       mover_mark;
    logic [1:0]       opp_mark;
    logic [15:0]      occ_ext;
    logic             offer_legal;
    logic             accept;
    logic             expire;
    logic             start_ok;

    // Select the offer of whichever side is on move; the other side is ignored.
    always_comb begin
        in_wait     = 1'b0;
        offer_valid = 1'b0;
        offer_pos   = 4'd0;
        mover_mark  = MARK_NONE;
        opp_mark    = MARK_NONE;
        case (state)
            S_WAIT_PL: begin
                in_wait     = 1'b1;
                offer_valid = pl_valid;
                offer_pos   = pl_pos;
                mover_mark  = MARK_PL;
                opp_mark    = MARK_PC;
            end
            S_WAIT_PC: begin
                in_wait     = 1'b1;
                offer_valid = pc_valid;
                offer_pos   = pc_pos;
                mover_mark  = MARK_PC;
                opp_mark    = MARK_PL;
            end
            default: begin
            end
        endcase
    end

    // Positions 9..15 are treated as permanently occupied so that a single
    // lookup covers both the range check and the occupancy check.
    assign occ_ext     = {7'h7f, cell_occ};
    assign offer_legal = ~occ_ext[offer_pos];
    assign accept      = offer_valid & offer_legal;
    assign reject      = offer_valid & ~offer_legal;
    assign expire      = TIMEOUT_ON && in_wait && (wait_cnt == TIMEOUT_LAST);
    assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));

    // Next-state decision; an accept in the expiry cycle wins over the forfeit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = first_q ? S_WAIT_PC : S_WAIT_PL;
            end
            S_WAIT_PL, S_WAIT_PC: begin
                if (accept) begin
                    state_nxt = S_WRITE;
                end else if (expire) begin
                    state_nxt = S_DONE;
                end
            end
            S_WRITE: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (win || full) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = (mark_q == MARK_PL) ? S_WAIT_PC : S_WAIT_PL;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the accepted move so WRITE can replay it to the board.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= 4'd0;
            mark_q <= MARK_NONE;
        end else if (accept) begin
            pos_q  <= offer_pos;
            mark_q <= mover_mark;
        end
    end

    // Per-turn stall counter: held at zero outside WAIT so each WAIT starts fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Game bookkeeping: who starts, move count, final result and forfeit pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_q    <= 1'b0;
            move_cnt_q <= 4'd0;
            result_q   <= MARK_NONE;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= expire && !accept;
            if (start_ok) begin
                first_q    <= first_comp;
                move_cnt_q <= 4'd0;
                result_q   <= MARK_NONE;
            end
            if (state == S_WRITE) begin
                move_cnt_q <= move_cnt_q + 4'd1;
            end
            if (state == S_CHECK) begin
                if (win) begin
                    result_q <= mark_q;
                end else if (full) begin
                    result_q <= RES_DRAW;
                end
            end
            if (expire && !accept) begin
                result_q <= opp_mark;
            end
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        pl_ready  = 1'b0;
        pc_ready  = 1'b0;
        turn      = MARK_NONE;
        wr_en     = 9'd0;
        wr_mark   = MARK_NONE;
        board_clr = 1'b0;
        game_over = 1'b0;
        case (state)
            S_CLEAR: begin
                board_clr = 1'b1;
            end
            S_WAIT_PL: begin
                pl_ready = 1'b1;
                turn     = MARK_PL;
            end
            S_WAIT_PC: begin
                pc_ready = 1'b1;
                turn     = MARK_PC;
            end
            S_WRITE: begin
                wr_en   = 9'd1 << pos_q;
                wr_mark = mark_q;
            end
            S_DONE: begin
                game_over = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign timeout  = timeout_q;
    assign result   = result_q;
    assign move_cnt = move_cnt_q;

endmodule
